// File: rtl/sha256_bus_master.sv
// Register-bus master that feeds one 512-bit block to a memory-mapped SHA-256/224 core,
// waits for completion by polling status, and returns the 256-bit digest.
module sha256_bus_master #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned POLL_LIMIT    = 1024
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic         blk_mode,
   output logic         dig_valid,
   input  logic         dig_ready,
   output logic [255:0] dig_data,
   output logic         cs,
   output logic         we,
   output logic [7:0]   address,
   output logic [31:0]  write_data,
   input  logic [31:0]  read_data,
   input  logic         error,
   output logic         busy,
   output logic         timeout,
   output logic         bus_err
);

   localparam int unsigned CNT_W  = (SETTLE_CYCLES > 16) ? $clog2(SETTLE_CYCLES) : 4;
   localparam int unsigned POLL_W = (POLL_LIMIT > 2) ? $clog2(POLL_LIMIT) : 1;

   typedef enum logic [2:0] {IDLE, WR_BLK, WR_CTRL, SETTLE, POLL, RD_DIG, DONE} state_t;

   state_t              state;
   logic [511:0]        blk_shift;
   logic                first_q;
   logic                mode_q;
   logic [CNT_W-1:0]    cnt;
   logic [POLL_W-1:0]   poll_cnt;
   logic                poll_done;

   always_comb begin
      poll_done = (read_data[1:0] == 2'b11);
   end

   // Bus outputs are registered, so each branch loads the values for the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         blk_ready  <= 1'b1;
         dig_valid  <= 1'b0;
         dig_data   <= '0;
         cs         <= 1'b0;
         we         <= 1'b0;
         address    <= '0;
         write_data <= '0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
         bus_err    <= 1'b0;
         blk_shift  <= '0;
         first_q    <= 1'b0;
         mode_q     <= 1'b0;
         cnt        <= '0;
         poll_cnt   <= '0;
      end else begin
         timeout <= 1'b0;
         if (cs && error) begin
            bus_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (blk_valid) begin
                  state      <= WR_BLK;
                  blk_ready  <= 1'b0;
                  busy       <= 1'b1;
                  bus_err    <= 1'b0;
                  first_q    <= blk_first;
                  mode_q     <= blk_mode;
                  blk_shift  <= {blk_data[479:0], 32'h0};
                  cs         <= 1'b1;
                  we         <= 1'b1;
                  address    <= 8'h10;
                  write_data <= blk_data[511:480];
                  cnt        <= '0;
               end
            end
            WR_BLK: begin
               if (cnt == CNT_W'(15)) begin
                  state      <= WR_CTRL;
                  address    <= 8'h08;
                  write_data <= {29'h0, mode_q, ~first_q, first_q};
                  cnt        <= '0;
               end else begin
                  cnt        <= cnt + CNT_W'(1);
                  address    <= address + 8'h01;
                  write_data <= blk_shift[511:480];
                  blk_shift  <= {blk_shift[479:0], 32'h0};
               end
            end
            WR_CTRL: begin
               write_data <= '0;
               we         <= 1'b0;
               if (SETTLE_CYCLES == 0) begin
                  state    <= POLL;
                  address  <= 8'h09;
                  poll_cnt <= '0;
               end else begin
                  state   <= SETTLE;
                  cs      <= 1'b0;
                  address <= '0;
               end
            end
            SETTLE: begin
               if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  state    <= POLL;
                  cs       <= 1'b1;
                  address  <= 8'h09;
                  poll_cnt <= '0;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            POLL: begin
               if (poll_done) begin
                  state   <= RD_DIG;
                  address <= 8'h20;
                  cnt     <= '0;
               end else if (poll_cnt == POLL_W'(POLL_LIMIT - 1)) begin
                  state     <= IDLE;
                  cs        <= 1'b0;
                  address   <= '0;
                  blk_ready <= 1'b1;
                  busy      <= 1'b0;
                  timeout   <= 1'b1;
                  poll_cnt  <= '0;
               end else begin
                  poll_cnt <= poll_cnt + POLL_W'(1);
               end
            end
            RD_DIG: begin
               // Shifting in from the bottom leaves word 0 at [255:224] after eight reads.
               dig_data <= {dig_data[223:0], read_data};
               if (cnt == CNT_W'(7)) begin
                  state     <= DONE;
                  cs        <= 1'b0;
                  address   <= '0;
                  dig_valid <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt     <= cnt + CNT_W'(1);
                  address <= address + 8'h01;
               end
            end
            DONE: begin
               if (dig_ready) begin
                  state     <= IDLE;
                  dig_valid <= 1'b0;
                  blk_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_bus_master.sv
// Bench for sha256_bus_master: a register slave with a real SHA-256/224 compression model,
// table-driven block vectors, and hand sequences for timeout, back-pressure and reset.
module tb_sha256_bus_master;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic         blk_first = 1'b0;
   logic         blk_mode = 1'b0;
   logic         dig_valid;
   logic         dig_ready = 1'b0;
   logic [255:0] dig_data;
   logic         cs;
   logic         we;
   logic [7:0]   address;
   logic [31:0]  write_data;
   logic [31:0]  read_data;
   logic         error;
   logic         busy;
   logic         timeout;
   logic         bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sha256_bus_master #(.SETTLE_CYCLES(4), .POLL_LIMIT(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .blk_first(blk_first), .blk_mode(blk_mode),
      .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
      .cs(cs), .we(we), .address(address), .write_data(write_data),
      .read_data(read_data), .error(error),
      .busy(busy), .timeout(timeout), .bus_err(bus_err)
   );

   logic [31:0] k_tab [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [31:0] blk_regs [16];
   logic [31:0] hs [8];
   int          polls_seen = 0;
   int          busy_polls = 0;
   int          poll_total = 0;
   int          cs_total = 0;
   logic        never_ready = 1'b0;
   logic        err_inj = 1'b0;
   logic [7:0]  err_addr = 8'h00;
   logic [7:0]  wq_addr [$];
   logic [31:0] wq_data [$];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void sha_init(input logic m);
      if (m) hs = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      else   hs = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
   endfunction

   function automatic void sha_compress();
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk_regs[i];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      a = hs[0]; b = hs[1]; c = hs[2]; d = hs[3]; e = hs[4]; f = hs[5]; g = hs[6]; h = hs[7];
      for (int i = 0; i < 64; i++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hs[0] += a; hs[1] += b; hs[2] += c; hs[3] += d;
      hs[4] += e; hs[5] += f; hs[6] += g; hs[7] += h;
   endfunction

   always_comb begin
      read_data = '0;
      if (address == 8'h09)
         read_data = {30'h0, (!never_ready && polls_seen >= busy_polls) ? 2'b11 : 2'b01};
      else if (address[7:3] == 5'b00100)
         read_data = hs[address[2:0]];
   end

   assign error = err_inj && cs && (address == err_addr);

   always @(posedge clk) begin
      if (cs) begin
         cs_total <= cs_total + 1;
         if (we) begin
            wq_addr.push_back(address);
            wq_data.push_back(write_data);
            if (address[7:4] == 4'h1) blk_regs[address[3:0]] <= write_data;
            else if (address == 8'h08) begin
               if (write_data[0]) sha_init(write_data[2]);
               sha_compress();
               polls_seen <= 0;
            end
         end else if (address == 8'h09) begin
            polls_seen <= polls_seen + 1;
            poll_total <= poll_total + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send(input logic [511:0] d, input logic f, input logic m);
      @(negedge clk);
      blk_data = d; blk_first = f; blk_mode = m; blk_valid = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
   endtask

   // cyc counts negedges after the accepting edge; cyc-1 is the edge-to-edge latency.
   task automatic wait_dv(output int cyc);
      cyc = 1;
      while (!dig_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   typedef struct {
      logic [511:0] blk;
      logic         first;
      logic         mode;
      int           polls;
      logic [7:0]   eaddr;
      logic [31:0]  exp_ctrl;
      logic [255:0] exp_dig;
      logic [255:0] dig_mask;
      logic         exp_err;
   } vec_t;

   localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] NIST1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] NIST2 = {480'h0, 32'h000001c0};
   localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_NIST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] DIG_224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
   localparam logic [255:0] M256 = {256{1'b1}};
   localparam logic [255:0] M224 = {{224{1'b1}}, 32'h0};

   vec_t vecs [4];

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic ok;
      logic [511:0] blk;
      logic [39:0] ctrl_act;
      int p0, c0, bad;
      logic saw_dv;

      vecs[0] = '{ABC,   1'b1, 1'b1, 0, 8'h00, 32'h5, DIG_ABC,  M256, 1'b0};
      vecs[1] = '{NIST1, 1'b1, 1'b1, 2, 8'h15, 32'h5, '0,       '0,   1'b1};
      vecs[2] = '{NIST2, 1'b0, 1'b1, 1, 8'h00, 32'h6, DIG_NIST, M256, 1'b0};
      vecs[3] = '{ABC,   1'b1, 1'b0, 0, 8'h09, 32'h1, DIG_224,  M224, 1'b1};

      #12;
      chk("reset_outs", {blk_ready, dig_valid, cs, we, address, write_data, busy, timeout, bus_err},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0});
      chk("reset_dig", dig_data, '0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         busy_polls = vecs[i].polls;
         err_addr = vecs[i].eaddr;
         err_inj = (vecs[i].eaddr != 8'h00);
         wq_addr.delete();
         wq_data.delete();
         send(vecs[i].blk, vecs[i].first, vecs[i].mode);
         wait_dv(cyc);
         chk($sformatf("v%0d_dig_valid", i), dig_valid, 1'b1);
         chk($sformatf("v%0d_latency", i), cyc - 1, 30 + vecs[i].polls);
         chk($sformatf("v%0d_busy_ready", i), {busy, blk_ready}, 2'b10);
         chk($sformatf("v%0d_nwrites", i), wq_addr.size(), 17);
         blk = vecs[i].blk;
         ok = 1'b1;
         for (int j = 0; j < 16; j++)
            if (j >= wq_addr.size() || wq_addr[j] != 8'h10 + j[7:0] || wq_data[j] != blk[511-32*j -: 32])
               ok = 1'b0;
         chk($sformatf("v%0d_wr_seq", i), ok, 1'b1);
         ctrl_act = (wq_addr.size() >= 17) ? {wq_addr[16], wq_data[16]} : '0;
         chk($sformatf("v%0d_ctrl", i), ctrl_act, {8'h08, vecs[i].exp_ctrl});
         if (vecs[i].dig_mask != '0)
            chk($sformatf("v%0d_digest", i), dig_data & vecs[i].dig_mask, vecs[i].exp_dig & vecs[i].dig_mask);
         chk($sformatf("v%0d_bus_err", i), bus_err, vecs[i].exp_err);
         dig_ready = 1'b1;
         @(negedge clk);
         dig_ready = 1'b0;
         chk($sformatf("v%0d_idle", i), {blk_ready, dig_valid, busy}, 3'b100);
         err_inj = 1'b0;
      end

      // Status never completes: exactly POLL_LIMIT reads then a one-cycle timeout.
      never_ready = 1'b1;
      busy_polls = 0;
      p0 = poll_total;
      send(ABC, 1'b1, 1'b1);
      cyc = 1;
      saw_dv = 1'b0;
      while (!timeout && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (dig_valid) saw_dv = 1'b1;
      end
      chk("to_pulse", timeout, 1'b1);
      chk("to_latency", cyc - 1, 29);
      chk("to_polls", poll_total - p0, 8);
      chk("to_idle", {blk_ready, busy, cs}, 3'b100);
      chk("to_dig_hold", dig_data & M224, DIG_224);
      @(negedge clk);
      chk("to_one_cycle", timeout, 1'b0);
      chk("to_no_dv", {saw_dv, dig_valid}, 2'b00);
      never_ready = 1'b0;

      // Digest back-pressure with blk_valid pulses that must be ignored.
      send(ABC, 1'b1, 1'b1);
      wait_dv(cyc);
      chk("bp_dig_valid", dig_valid, 1'b1);
      c0 = cs_total;
      bad = 0;
      for (int t = 0; t < 20; t++) begin
         blk_valid = (t >= 5 && t < 8);
         blk_data = {16{32'hdeadbeef}};
         @(negedge clk);
         if (dig_data != DIG_ABC || !dig_valid || blk_ready) bad++;
      end
      blk_valid = 1'b0;
      chk("bp_stable", bad, 0);
      chk("bp_no_bus", cs_total - c0, 0);
      dig_ready = 1'b1;
      @(negedge clk);
      dig_ready = 1'b0;
      chk("bp_release", {blk_ready, dig_valid, busy}, 3'b100);
      @(negedge clk);
      chk("bp_no_accept", {cs, busy}, 2'b00);

      // Asynchronous reset in the middle of the block writes.
      send(ABC, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      chk("rst_pre_cs", {cs, we}, 2'b11);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_outs", {blk_ready, dig_valid, cs, we, address, write_data, busy, timeout, bus_err},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0});
      chk("rst_async_dig", dig_data, '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      c0 = cs_total;
      repeat (10) @(negedge clk);
      chk("rst_quiet", cs_total - c0, 0);
      chk("rst_idle", {blk_ready, busy}, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
